// File: rtl/npu_dp_sram.sv
module npu_dp_sram #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DEPTH     = 16384,
  parameter int unsigned RD_LAT    = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   address,
  input  logic [ADDR_W-1:0]   address2,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W/8-1:0] byteenable2,
  input  logic                chipselect,
  input  logic                chipselect2,
  input  logic                write,
  input  logic                write2,
  input  logic                read,
  input  logic                read2,
  input  logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W-1:0]   writedata2,
  input  logic                clken,
  input  logic                clken2,
  output logic [DATA_W-1:0]   readdata,
  output logic [DATA_W-1:0]   readdata2,
  output logic                readdatavalid,
  output logic                readdatavalid2,
  output logic                collision,
  input  logic                collision_clr
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]        cs, ck, wr, rd, acc, we, re, in_rng;
  logic [ADDR_W-1:0] addr  [2];
  logic [IDX_W-1:0]  idx   [2];
  logic [BE_W-1:0]   be    [2];
  logic [DATA_W-1:0] wdata [2];
  logic              coll_set;

  assign cs = {chipselect2, chipselect};
  assign ck = {clken2, clken};
  assign wr = {write2, write};
  assign rd = {read2, read};

  always_comb begin
    addr[0]  = address;
    addr[1]  = address2;
    idx[0]   = address[IDX_W-1:0];
    idx[1]   = address2[IDX_W-1:0];
    be[0]    = byteenable;
    be[1]    = byteenable2;
    wdata[0] = writedata;
    wdata[1] = writedata2;
  end

  if (64'(DEPTH) < (64'(1) << ADDR_W)) begin : g_rng_chk
    assign in_rng = {({1'b0, address2} < (ADDR_W+1)'(DEPTH)),
                     ({1'b0, address}  < (ADDR_W+1)'(DEPTH))};
  end else begin : g_rng_full
    assign in_rng = '1;
  end

  // Nothing is accepted while reset is sampled, so writes on the reset edge are dropped.
  assign acc      = cs & ck & {2{~reset}};
  assign we       = acc & wr & in_rng;
  assign re       = acc & rd & ~wr;
  assign coll_set = we[0] & we[1] & (address == address2);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] raw_q [2];

  // s2 lanes are assigned before s1 lanes, so s1 takes any lane both ports enable.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (we[1] && be[1][i]) mem_q[idx[1]][8*i +: 8] <= wdata[1][8*i +: 8];
    end
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (we[0] && be[0][i]) mem_q[idx[0]][8*i +: 8] <= wdata[0][8*i +: 8];
    end
    for (int unsigned p = 0; p < 2; p++) begin
      if (re[p] && in_rng[p]) raw_q[p] <= mem_q[idx[p]];
    end
  end

  logic [1:0]        v0_q, keep_q;
  logic [DATA_W-1:0] d0 [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      v0_q   <= '0;
      keep_q <= '0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (ck[p]) v0_q[p] <= re[p];
        if (re[p]) keep_q[p] <= in_rng[p];
      end
    end
  end

`ifdef NPU_SRAM_FWD_EN
  function automatic logic [DATA_W-1:0] lane_mask(input logic [BE_W-1:0] b);
    lane_mask = '0;
    for (int unsigned i = 0; i < BE_W; i++) lane_mask[8*i +: 8] = {8{b[i]}};
  endfunction

  logic [1:0]        fwd_hit;
  logic [DATA_W-1:0] fmask_q [2];
  logic [DATA_W-1:0] fdata_q [2];

  assign fwd_hit = {we[0] & (address2 == address), we[1] & (address == address2)};

  // The array read returns old data; the other port's written lanes are overlaid here.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned p = 0; p < 2; p++) begin
        fmask_q[p] <= '0;
        fdata_q[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (re[p]) begin
          fmask_q[p] <= fwd_hit[p] ? lane_mask(be[1-p]) : '0;
          fdata_q[p] <= wdata[1-p];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      d0[p] = '0;
      if (keep_q[p]) d0[p] = (raw_q[p] & ~fmask_q[p]) | (fdata_q[p] & fmask_q[p]);
    end
  end
`else
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      d0[p] = keep_q[p] ? raw_q[p] : '0;
    end
  end
`endif

  if (RD_LAT == 2) begin : g_lat2
    logic [1:0]        v1_q;
    logic [DATA_W-1:0] d1_q [2];

    always_ff @(posedge clk) begin
      if (reset) begin
        v1_q <= '0;
        for (int unsigned p = 0; p < 2; p++) d1_q[p] <= '0;
      end else begin
        for (int unsigned p = 0; p < 2; p++) begin
          if (ck[p]) begin
            v1_q[p] <= v0_q[p];
            if (v0_q[p]) d1_q[p] <= d0[p];
          end
        end
      end
    end

    assign readdata       = d1_q[0];
    assign readdata2      = d1_q[1];
    assign readdatavalid  = v1_q[0] & ck[0];
    assign readdatavalid2 = v1_q[1] & ck[1];
  end else begin : g_lat1
    assign readdata       = d0[0];
    assign readdata2      = d0[1];
    assign readdatavalid  = v0_q[0] & ck[0];
    assign readdatavalid2 = v0_q[1] & ck[1];
  end

  logic collision_q, collision_d;

  always_comb begin
    collision_d = collision_q;
    if (collision_clr) collision_d = 1'b0;
    if (coll_set)      collision_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) collision_q <= 1'b0;
    else       collision_q <= collision_d;
  end

  assign collision = collision_q;

endmodule

// File: tb/tb_npu_dp_sram.sv
// Directed bench: two npu_dp_sram instances (RD_LAT=1 as A, RD_LAT=2 as B, DEPTH=1024) on shared stimulus.
module tb_npu_dp_sram;

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] address, address2;
   logic [1:0]  byteenable, byteenable2;
   logic        chipselect, chipselect2, write, write2, read, read2;
   logic [15:0] writedata, writedata2;
   logic        clken, clken2, collision_clr;

   logic [15:0] rdA, rd2A, rdB, rd2B;
   logic        rvA, rv2A, rvB, rv2B, collA, collB;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   npu_dp_sram #(.DATA_W(16), .ADDR_W(14), .DEPTH(1024), .RD_LAT(1)) u_a (
      .clk(clk), .reset(reset),
      .address(address), .address2(address2),
      .byteenable(byteenable), .byteenable2(byteenable2),
      .chipselect(chipselect), .chipselect2(chipselect2),
      .write(write), .write2(write2), .read(read), .read2(read2),
      .writedata(writedata), .writedata2(writedata2),
      .clken(clken), .clken2(clken2),
      .readdata(rdA), .readdata2(rd2A),
      .readdatavalid(rvA), .readdatavalid2(rv2A),
      .collision(collA), .collision_clr(collision_clr)
   );

   npu_dp_sram #(.DATA_W(16), .ADDR_W(14), .DEPTH(1024), .RD_LAT(2)) u_b (
      .clk(clk), .reset(reset),
      .address(address), .address2(address2),
      .byteenable(byteenable), .byteenable2(byteenable2),
      .chipselect(chipselect), .chipselect2(chipselect2),
      .write(write), .write2(write2), .read(read), .read2(read2),
      .writedata(writedata), .writedata2(writedata2),
      .clken(clken), .clken2(clken2),
      .readdata(rdB), .readdata2(rd2B),
      .readdatavalid(rvB), .readdatavalid2(rv2B),
      .collision(collB), .collision_clr(collision_clr)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clr_all();
      chipselect = 1'b0; chipselect2 = 1'b0;
      write = 1'b0; write2 = 1'b0; read = 1'b0; read2 = 1'b0;
      collision_clr = 1'b0;
   endtask

   task automatic wr1(input logic [13:0] a, input logic [15:0] d, input logic [1:0] b);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = b;
      @(posedge clk); #1;
      clr_all();
   endtask

   // Issues one read and checks that A answers one cycle later and B two cycles later.
   task automatic rd_chk(input int port, input logic [13:0] a, input logic [15:0] exp, input string tag);
      if (port == 1) begin
         chipselect = 1'b1; read = 1'b1; address = a;
      end else begin
         chipselect2 = 1'b1; read2 = 1'b1; address2 = a;
      end
      @(posedge clk); #1;
      clr_all();
      @(negedge clk);
      if (port == 1) begin
         check_eq({tag, "_vA"}, rvA, 1);
         check_eq({tag, "_dA"}, rdA, exp);
         check_eq({tag, "_vB_early"}, rvB, 0);
      end else begin
         check_eq({tag, "_vA"}, rv2A, 1);
         check_eq({tag, "_dA"}, rd2A, exp);
         check_eq({tag, "_vB_early"}, rv2B, 0);
      end
      @(negedge clk);
      if (port == 1) begin
         check_eq({tag, "_vA_once"}, rvA, 0);
         check_eq({tag, "_vB"}, rvB, 1);
         check_eq({tag, "_dB"}, rdB, exp);
      end else begin
         check_eq({tag, "_vA_once"}, rv2A, 0);
         check_eq({tag, "_vB"}, rv2B, 1);
         check_eq({tag, "_dB"}, rd2B, exp);
      end
   endtask

   task automatic all_zero(input string tag);
      check_eq({tag, "_A"}, {rdA, rd2A}, 0);
      check_eq({tag, "_B"}, {rdB, rd2B}, 0);
      check_eq({tag, "_vld"}, {rvA, rv2A, rvB, rv2B}, 0);
      check_eq({tag, "_coll"}, {collA, collB}, 0);
   endtask

   // Stream monitor
   logic        mon_en = 1'b0;
   int          bad_v  = 0;
   logic [15:0] qA[$], qB[$];

   always @(negedge clk) begin
      if (mon_en) begin
         if (rv2A) qA.push_back(rd2A);
         if (rv2B) qB.push_back(rd2B);
         if (!clken2 && (rv2A || rv2B)) bad_v++;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] exp_fwd;
      logic [15:0] stream_exp [4];
      stream_exp[0] = 16'hA000; stream_exp[1] = 16'hA111;
      stream_exp[2] = 16'hA222; stream_exp[3] = 16'h5A5A;

      clr_all();
      address = '0; address2 = '0; byteenable = '0; byteenable2 = '0;
      writedata = '0; writedata2 = '0;
      clken = 1'b1; clken2 = 1'b1; reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      all_zero("reset");

      // Cross-port write then read
      wr1(14'd5, 16'hBEEF, 2'b11);
      rd_chk(2, 14'd5, 16'hBEEF, "s2_rd5");

      // Partial byte-lane write
      wr1(14'd7, 16'h1234, 2'b11);
      wr1(14'd7, 16'hAB00, 2'b10);
      rd_chk(1, 14'd7, 16'hAB34, "be_merge");

      // Same-address write collision
      chipselect = 1'b1; write = 1'b1; address = 14'd9; writedata = 16'h1111; byteenable = 2'b01;
      chipselect2 = 1'b1; write2 = 1'b1; address2 = 14'd9; writedata2 = 16'h2222; byteenable2 = 2'b11;
      @(posedge clk); #1; clr_all();
      @(negedge clk);
      check_eq("coll_set", {collA, collB}, 2'b11);
      rd_chk(1, 14'd9, 16'h2211, "coll_data");
      check_eq("coll_sticky", {collA, collB}, 2'b11);
      collision_clr = 1'b1;
      @(posedge clk); #1; clr_all();
      @(negedge clk);
      check_eq("coll_clr", {collA, collB}, 2'b00);
      chipselect = 1'b1; write = 1'b1; address = 14'd9; writedata = 16'h3333; byteenable = 2'b11;
      chipselect2 = 1'b1; write2 = 1'b1; address2 = 14'd9; writedata2 = 16'h4444; byteenable2 = 2'b11;
      collision_clr = 1'b1;
      @(posedge clk); #1; clr_all();
      @(negedge clk);
      check_eq("coll_set_wins", {collA, collB}, 2'b11);
      rd_chk(2, 14'd9, 16'h3333, "coll_s1_all");

      // Mixed-port read during write
      wr1(14'd3, 16'h0000, 2'b11);
`ifdef NPU_SRAM_FWD_EN
      exp_fwd = 16'h5A5A;
`else
      exp_fwd = 16'h0000;
`endif
      chipselect = 1'b1; write = 1'b1; address = 14'd3; writedata = 16'h5A5A; byteenable = 2'b11;
      rd_chk(2, 14'd3, exp_fwd, "rdw");
      rd_chk(2, 14'd3, 16'h5A5A, "rdw_after");

      // Streamed reads with clken2 dropped for two cycles
      wr1(14'd0, 16'hA000, 2'b11);
      wr1(14'd1, 16'hA111, 2'b11);
      wr1(14'd2, 16'hA222, 2'b11);
      mon_en = 1'b1;
      chipselect2 = 1'b1; read2 = 1'b1; address2 = 14'd0;
      @(posedge clk); #1 address2 = 14'd1;
      @(posedge clk); #1 clken2 = 1'b0; address2 = 14'd2;
      @(posedge clk); #1;
      @(posedge clk); #1 clken2 = 1'b1;
      @(posedge clk); #1 address2 = 14'd3;
      @(posedge clk); #1 clr_all();
      repeat (5) @(posedge clk);
      #1 mon_en = 1'b0;
      check_eq("stream_cntA", qA.size(), 4);
      check_eq("stream_cntB", qB.size(), 4);
      check_eq("stream_gap", bad_v, 0);
      for (int i = 0; i < 4; i++) begin
         if (i < qA.size()) check_eq($sformatf("streamA_%0d", i), qA[i], stream_exp[i]);
         if (i < qB.size()) check_eq($sformatf("streamB_%0d", i), qB[i], stream_exp[i]);
      end

      // Out-of-range read returns zero with valid
      rd_chk(1, 14'd1024, 16'h0000, "oor");

      // Reset one cycle after a read; write on the reset cycle is dropped
      rd_chk(1, 14'd7, 16'hAB34, "pre_rst");
      chipselect = 1'b1; read = 1'b1; address = 14'd5;
      @(posedge clk); #1;
      clr_all();
      reset = 1'b1;
      chipselect = 1'b1; write = 1'b1; address = 14'd5; writedata = 16'h0000; byteenable = 2'b11;
      @(posedge clk); #1;
      reset = 1'b0; clr_all();
      @(negedge clk);
      all_zero("rst_inflight");
      @(negedge clk);
      check_eq("rst_no_vldB", rvB, 0);
      rd_chk(1, 14'd5, 16'hBEEF, "rst_no_write");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
